// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice.
//   - cntrl op encodings (OP_*)
//   - one-hot slice enable constants (EN_*)
//   - sequencer state enum (IDLE/RUN/DONE)
//   - decode(): maps a 3-bit op to the one-hot slice enable
//   - is_arith(): true for the enables that use the carry chain (ADD/SUB)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    localparam logic [7:0] EN_NONE = 8'h00;
    localparam logic [7:0] EN_PASS = 8'h01;
    localparam logic [7:0] EN_ADD  = 8'h04;
    localparam logic [7:0] EN_SUB  = 8'h08;
    localparam logic [7:0] EN_AND  = 8'h10;
    localparam logic [7:0] EN_OR   = 8'h20;
    localparam logic [7:0] EN_XOR  = 8'h40;
    localparam logic [7:0] EN_NOP  = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Undefined ops (001/111) select the NOP enable so the slice outputs 0.
    function automatic logic [7:0] decode(input logic [2:0] op);
        logic [7:0] en;
        case (op)
            OP_PASS: en = EN_PASS;
            OP_ADD:  en = EN_ADD;
            OP_SUB:  en = EN_SUB;
            OP_AND:  en = EN_AND;
            OP_OR:   en = EN_OR;
            OP_XOR:  en = EN_XOR;
            default: en = EN_NOP;
        endcase
        return en;
    endfunction

    function automatic logic is_arith(input logic [7:0] en);
        return (en == EN_ADD) || (en == EN_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_serial_ctrl_if
// Request/response bus of the bit-serial ALU sequencer.
//   Request : start_valid/start_ready handshake carrying cntrl, a, b
//   Response: result_valid/result_ready handshake carrying result and
//             the NZVC flags (negative, zero, overflow, carry_out)
//   enabler : one-hot function enable currently presented to the 1-bit slice
// Modports: master = requester/consumer side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       enabler;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start_valid, cntrl, a, b, result_ready,
        input  start_ready, enabler, result_valid, result,
               negative, zero, overflow, carry_out
    );

    modport slave (
        input  start_valid, cntrl, a, b, result_ready,
        output start_ready, enabler, result_valid, result,
               negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/alu_slice_1b.sv
// -----------------------------------------------------------------------------
// alu_slice_1b
// Combinational 1-bit ALU slice driven by a one-hot function enable.
//   a, b     : operand bits
//   cin      : carry in (used by ADD/SUB only)
//   enabler  : one-hot function select (EN_* from alu_pkg)
//   out      : result bit
//   cout     : carry out (0 for every non-arithmetic function)
// SUB is A + ~B + cin: the slice inverts b itself whenever the SUB enable
// is set, the sequencer only has to seed cin=1 for the first bit.
// -----------------------------------------------------------------------------
module alu_slice_1b
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [7:0] enabler,
    output logic       out,
    output logic       cout
);

    logic b_eff;

    assign b_eff = enabler[3] ? ~b : b;

    always_comb begin
        out  = 1'b0;
        cout = 1'b0;
        case (enabler)
            EN_PASS: out = b;
            EN_ADD,
            EN_SUB: begin
                out  = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            EN_AND:  out = a & b;
            EN_OR:   out = a | b;
            EN_XOR:  out = a ^ b;
            default: begin
                out  = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// -----------------------------------------------------------------------------
// alu_serial_ctrl
// Bit-serial ALU sequencer. Accepts an op and two WIDTH-bit operands, then
// walks them LSB first through a single alu_slice_1b, one bit per cycle,
// keeping the carry in a register between bits. The result and NZVC flags
// are offered on a second valid/ready handshake.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : alu_serial_ctrl_if.slave (request, response, enabler)
// Parameters:
//   WIDTH    : operand/result width (>= 2)
// Configuration macro:
//   ALU_SERIAL_BYPASS_EN : when defined, PASS_B/AND/OR/XOR/no-op are
//                          computed in parallel at the accept edge and go
//                          straight to DONE; ADD/SUB stay serial.
// -----------------------------------------------------------------------------
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_serial_ctrl_if.slave    bus
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic [7:0]       enabler_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic             negative_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             carry_out_reg;
    logic             start_ready_c;
    logic             result_valid_c;
    logic             accept;
    logic             last_bit;
    logic             bypass;
    logic             slice_out;
    logic             slice_cout;

    assign accept   = (state == IDLE) && bus.start_valid;
    assign last_bit = (idx == IDX_W'(WIDTH - 1));

`ifdef ALU_SERIAL_BYPASS_EN
    logic [WIDTH-1:0] bypass_result;

    assign bypass = !is_arith(decode(bus.cntrl));

    // Full-width result for the ops that need no carry chain.
    always_comb begin
        bypass_result = '0;
        case (bus.cntrl)
            OP_PASS: bypass_result = bus.b;
            OP_AND:  bypass_result = bus.a & bus.b;
            OP_OR:   bypass_result = bus.a | bus.b;
            OP_XOR:  bypass_result = bus.a ^ bus.b;
            default: bypass_result = '0;
        endcase
    end
`else
    assign bypass = 1'b0;
`endif

    alu_slice_1b u_slice (
        .a       (a_reg[idx]),
        .b       (b_reg[idx]),
        .cin     (carry),
        .enabler (enabler_reg),
        .out     (slice_out),
        .cout    (slice_cout)
    );

    // Result with the current slice bit merged in; the final zero flag is
    // taken from this so it covers all WIDTH bits including the MSB.
    always_comb begin
        result_next      = result_reg;
        result_next[idx] = slice_out;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        start_ready_c  = 1'b0;
        result_valid_c = 1'b0;
        case (state)
            IDLE: begin
                start_ready_c = 1'b1;
                if (bus.start_valid) begin
                    next_state = bypass ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                result_valid_c = 1'b1;
                if (bus.result_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, per-bit result write-back and flag generation.
    // On the last bit the carry register still holds the carry into the
    // MSB, so overflow is that carry XOR the slice's final carry out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            enabler_reg   <= EN_NONE;
            carry         <= 1'b0;
            idx           <= '0;
            negative_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            carry_out_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg       <= bus.a;
                        b_reg       <= bus.b;
                        enabler_reg <= decode(bus.cntrl);
                        carry       <= (bus.cntrl == OP_SUB);
                        idx         <= '0;
`ifdef ALU_SERIAL_BYPASS_EN
                        if (bypass) begin
                            result_reg    <= bypass_result;
                            negative_reg  <= bypass_result[WIDTH-1];
                            zero_reg      <= (bypass_result == '0);
                            overflow_reg  <= 1'b0;
                            carry_out_reg <= 1'b0;
                        end
`endif
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry      <= slice_cout;
                    idx        <= idx + 1'b1;
                    if (last_bit) begin
                        idx           <= '0;
                        negative_reg  <= slice_out;
                        zero_reg      <= (result_next == '0);
                        overflow_reg  <= is_arith(enabler_reg) ? (carry ^ slice_cout) : 1'b0;
                        carry_out_reg <= is_arith(enabler_reg) ? slice_cout : 1'b0;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        enabler_reg <= EN_NONE;
                    end
                end
                default: begin
                    enabler_reg <= EN_NONE;
                end
            endcase
        end
    end

    assign bus.start_ready  = start_ready_c;
    assign bus.result_valid = result_valid_c;
    assign bus.enabler      = enabler_reg;
    assign bus.result       = result_reg;
    assign bus.negative     = negative_reg;
    assign bus.zero         = zero_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.carry_out    = carry_out_reg;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_ctrl
// Self-checking bench for alu_serial_ctrl (WIDTH=64). Expected results come
// from a wide-arithmetic reference model of the op set; latency expectations
// follow ALU_SERIAL_BYPASS_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_alu_serial_ctrl;

    localparam int W         = 64;
    localparam int LAT_LIMIT = 200;

    logic clk;
    logic reset_n;
    int   checks;
    int   passed;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole-word arithmetic with a 65-bit sum for carry.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] r, output logic [3:0] nzvc);
        logic [W:0] wide;
        logic       v;
        logic       c;
        v = 1'b0;
        c = 1'b0;
        r = '0;
        case (op)
            3'b000: r = bv;
            3'b010: begin
                wide = {1'b0, av} + {1'b0, bv};
                r = wide[W-1:0];
                c = wide[W];
                v = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
            end
            3'b011: begin
                wide = {1'b0, av} + {1'b0, ~bv} + 65'd1;
                r = wide[W-1:0];
                c = wide[W];
                v = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
            end
            3'b100: r = av & bv;
            3'b101: r = av | bv;
            3'b110: r = av ^ bv;
            default: r = '0;
        endcase
        nzvc = {r[W-1], (r == '0), v, c};
    endfunction

    function automatic logic [7:0] exp_enabler(input logic [2:0] op);
        logic [7:0] table_en [8];
        table_en = '{8'h01, 8'h80, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        return table_en[op];
    endfunction

    // Edges from the accept edge until result_valid is first seen high.
    function automatic int exp_latency(input logic [2:0] op);
`ifdef ALU_SERIAL_BYPASS_EN
        return (op == 3'b010 || op == 3'b011) ? W : 0;
`else
        return (op == 3'b000) ? W : W + 0 * int'(op);
`endif
    endfunction

    // Drives one request, waits (bounded) for the response, captures it and
    // completes the response handshake. Leaves the caller on a falling edge.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] res, output logic [3:0] nzvc,
                          output logic [7:0] en, output int lat);
        int guard;
        guard = 0;
        while (!bus.start_ready && guard < LAT_LIMIT) begin
            @(negedge clk);
            guard++;
        end
        bus.cntrl       = op;
        bus.a           = av;
        bus.b           = bv;
        bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.a           = {$urandom, $urandom};
        bus.b           = {$urandom, $urandom};
        lat = 0;
        while (!bus.result_valid && lat < LAT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
        res  = bus.result;
        nzvc = {bus.negative, bus.zero, bus.overflow, bus.carry_out};
        en   = bus.enabler;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b0;
        bus.cntrl        = 3'b000;
        bus.a            = '0;
        bus.b            = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.enabler !== 8'h00)
            $display("[TB] FAIL reset_handshake: ready=%b valid=%b en=%h, want 1 0 00",
                     bus.start_ready, bus.result_valid, bus.enabler);
        else passed++;
        checks++;
        if (bus.result !== '0 || {bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0000)
            $display("[TB] FAIL reset_result: result=%h nzvc=%b, want 0 0000", bus.result,
                     {bus.negative, bus.zero, bus.overflow, bus.carry_out});
        else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [W-1:0] res, av, bv, er;
        logic [3:0]   nzvc, en_nzvc;
        logic [7:0]   en;
        int           lat;
        run_op(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, res, nzvc, en, lat);
        checks++;
        if (res !== 64'h8000_0000_0000_0000 || nzvc !== 4'b1010)
            $display("[TB] FAIL add_overflow: result=%h nzvc=%b, want 8000000000000000 1010", res, nzvc);
        else passed++;
        checks++;
        if (lat !== W) $display("[TB] FAIL add_latency: got %0d, want %0d", lat, W);
        else passed++;
        checks++;
        if (en !== 8'h04) $display("[TB] FAIL add_enabler: got %h, want 04", en);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            model(3'b010, av, bv, er, en_nzvc);
            run_op(3'b010, av, bv, res, nzvc, en, lat);
            checks++;
            if (res !== er || nzvc !== en_nzvc)
                $display("[TB] FAIL add_random: %h+%h got %h/%b, want %h/%b", av, bv, res, nzvc, er, en_nzvc);
            else passed++;
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] res, av, bv, er;
        logic [3:0]   nzvc, en_nzvc;
        logic [7:0]   en;
        int           lat;
        run_op(3'b011, 64'h5, 64'h5, res, nzvc, en, lat);
        checks++;
        if (res !== 64'h0 || nzvc !== 4'b0101)
            $display("[TB] FAIL sub_equal: result=%h nzvc=%b, want 0 0101", res, nzvc);
        else passed++;
        checks++;
        if (en !== 8'h08) $display("[TB] FAIL sub_enabler: got %h, want 08", en);
        else passed++;
        run_op(3'b011, 64'h0, 64'h1, res, nzvc, en, lat);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF || nzvc !== 4'b1000)
            $display("[TB] FAIL sub_borrow: result=%h nzvc=%b, want ffffffffffffffff 1000", res, nzvc);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            av = {$urandom, $urandom};
            bv = (i == 0) ? {1'b1, 63'h0} : {$urandom, $urandom};
            model(3'b011, av, bv, er, en_nzvc);
            run_op(3'b011, av, bv, res, nzvc, en, lat);
            checks++;
            if (res !== er || nzvc !== en_nzvc)
                $display("[TB] FAIL sub_random: %h-%h got %h/%b, want %h/%b", av, bv, res, nzvc, er, en_nzvc);
            else passed++;
        end
    endtask

    task automatic test_logic();
        logic [W-1:0] res, er, av, bv;
        logic [3:0]   nzvc, en_nzvc;
        logic [7:0]   en;
        int           lat;
        logic [2:0]   ops [3];
        logic [W-1:0] want [3];
        ops  = '{3'b100, 3'b101, 3'b110};
        want = '{64'hF000, 64'hFFF0, 64'h0FF0};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 64'hF0F0, 64'hFF00, res, nzvc, en, lat);
            checks++;
            if (res !== want[i] || nzvc[1:0] !== 2'b00)
                $display("[TB] FAIL logic_fixed: op=%b got %h vc=%b, want %h 00", ops[i], res, nzvc[1:0], want[i]);
            else passed++;
            checks++;
            if (lat !== exp_latency(ops[i]) || en !== exp_enabler(ops[i]))
                $display("[TB] FAIL logic_timing: op=%b lat=%0d en=%h, want %0d %h",
                         ops[i], lat, en, exp_latency(ops[i]), exp_enabler(ops[i]));
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            model(ops[i], av, bv, er, en_nzvc);
            run_op(ops[i], av, bv, res, nzvc, en, lat);
            checks++;
            if (res !== er || nzvc !== en_nzvc)
                $display("[TB] FAIL logic_random: op=%b got %h/%b, want %h/%b", ops[i], res, nzvc, er, en_nzvc);
            else passed++;
        end
    endtask

    task automatic test_pass_nop();
        logic [W-1:0] res;
        logic [3:0]   nzvc;
        logic [7:0]   en;
        int           lat;
        run_op(3'b000, {$urandom, $urandom}, 64'hDEAD, res, nzvc, en, lat);
        checks++;
        if (res !== 64'hDEAD || nzvc !== 4'b0000 || en !== 8'h01)
            $display("[TB] FAIL pass_b: result=%h nzvc=%b en=%h, want dead 0000 01", res, nzvc, en);
        else passed++;
        checks++;
        if (lat !== exp_latency(3'b000))
            $display("[TB] FAIL pass_latency: got %0d, want %0d", lat, exp_latency(3'b000));
        else passed++;
        run_op(3'b111, {$urandom, $urandom}, {$urandom, $urandom}, res, nzvc, en, lat);
        checks++;
        if (res !== '0 || nzvc !== 4'b0100 || en !== 8'h80)
            $display("[TB] FAIL nop_111: result=%h nzvc=%b en=%h, want 0 0100 80", res, nzvc, en);
        else passed++;
        run_op(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, res, nzvc, en, lat);
        checks++;
        if (res !== '0 || nzvc !== 4'b0100 || en !== 8'h80)
            $display("[TB] FAIL nop_001: result=%h nzvc=%b en=%h, want 0 0100 80", res, nzvc, en);
        else passed++;
        checks++;
        if (bus.enabler !== 8'h00 || bus.start_ready !== 1'b1)
            $display("[TB] FAIL release_idle: en=%h ready=%b, want 00 1", bus.enabler, bus.start_ready);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] av, bv, er;
        logic [3:0]   en_nzvc;
        int           lat;
        int           bad;
        av = {$urandom, $urandom};
        bv = {$urandom, $urandom};
        model(3'b010, av, bv, er, en_nzvc);
        bus.cntrl = 3'b010; bus.a = av; bus.b = bv; bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (10) @(negedge clk);
        bus.cntrl = 3'b110; bus.a = '0; bus.b = '0; bus.start_valid = 1'b1;
        checks++;
        if (bus.start_ready !== 1'b0 || bus.result_valid !== 1'b0)
            $display("[TB] FAIL run_ready: ready=%b valid=%b, want 0 0", bus.start_ready, bus.result_valid);
        else passed++;
        repeat (5) @(negedge clk);
        bus.start_valid = 1'b0;
        lat = 15;
        while (!bus.result_valid && lat < LAT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== W || bus.result !== er || bus.enabler !== 8'h04)
            $display("[TB] FAIL run_ignore_start: lat=%0d result=%h en=%h, want %0d %h 04",
                     lat, bus.result, bus.enabler, W, er);
        else passed++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b1 || bus.start_ready !== 1'b0 || bus.result !== er ||
                {bus.negative, bus.zero, bus.overflow, bus.carry_out} !== en_nzvc)
                bad++;
        end
        checks++;
        if (bad !== 0) $display("[TB] FAIL done_hold: %0d unstable cycles, want 0", bad);
        else passed++;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1)
            $display("[TB] FAIL done_release: valid=%b ready=%b, want 0 1", bus.result_valid, bus.start_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] res;
        logic [3:0]   nzvc;
        logic [7:0]   en;
        int           lat;
        bus.cntrl = 3'b010; bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
        bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.enabler !== 8'h00 ||
            bus.result !== '0 || {bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0000)
            $display("[TB] FAIL mid_run_reset: ready=%b valid=%b en=%h result=%h, want 1 0 00 0",
                     bus.start_ready, bus.result_valid, bus.enabler, bus.result);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(3'b010, 64'd3, 64'd4, res, nzvc, en, lat);
        checks++;
        if (res !== 64'd7 || nzvc !== 4'b0000 || lat !== W)
            $display("[TB] FAIL add_after_reset: result=%h nzvc=%b lat=%0d, want 7 0000 %0d", res, nzvc, lat, W);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res, av, bv, er;
        logic [3:0]   nzvc, en_nzvc;
        logic [7:0]   en;
        logic [2:0]   op;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            model(op, av, bv, er, en_nzvc);
            run_op(op, av, bv, res, nzvc, en, lat);
            checks++;
            if (res !== er || nzvc !== en_nzvc || en !== exp_enabler(op) || lat !== exp_latency(op))
                $display("[TB] FAIL b2b_op: op=%b got %h/%b/%h/%0d, want %h/%b/%h/%0d", op, res, nzvc, en, lat,
                         er, en_nzvc, exp_enabler(op), exp_latency(op));
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_pass_nop();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
